comparator_serial: RTL and testbench
====================================

# comparator_serial

Parametrised, multi-cycle magnitude comparator. Compares two WIDTH-bit operands CHUNK bits at a time, MSB chunk first, and stops at the first differing chunk. Supports signed and unsigned modes. Uses a start/busy/valid handshake. Successor to the single-cycle 3-bit comparator; used where wide operands must not form one long combinational compare path.

## Interface
- WIDTH, 8: operand width in bits; must be ≥ 1.
- CHUNK, 2: bits compared per cycle; must satisfy 1 ≤ CHUNK ≤ WIDTH and WIDTH % CHUNK == 0. Otherwise elaboration fails.
- Derived NCHUNK = WIDTH/CHUNK and SW = $clog2(NCHUNK)+1. These are localparams, not overridable.
- i_clk  in  1  single clock, rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_start  in  1  request a comparison; sampled only when o_busy = 0.
- i_signed  in  1  1 = two's-complement compare, 0 = unsigned; latched with i_start.
- i_a  in  WIDTH  operand A; latched with i_start.
- i_b  in  WIDTH  operand B; latched with i_start.
- o_f  out  3  result, one-hot {gt, eq, lt}: 100 = A>B, 010 = A==B, 001 = A<B; 000 only after reset.
- o_valid  out  1  one-cycle pulse; o_f and o_steps are new.
- o_busy  out  1  comparison in progress.
- o_steps  out  SW  number of chunks examined for the current result (1..NCHUNK).

## Operation
- Reset (i_rst_n = 0, asynchronous, any state): state = IDLE, o_f = 000, o_valid = 0, o_busy = 0, o_steps = 0, operand registers = 0, chunk index = 0.
- FSM has two states, IDLE and CMP.
  - IDLE → CMP when i_start = 1. At that edge, i_a, i_b and i_signed are latched, chunk index = 0 (MSB chunk), and o_busy goes to 1.
  - CMP, chunk index k: the chunk comparator compares latched bits [WIDTH-1-k·CHUNK -: CHUNK].
    - Chunks differ: register gt/lt into o_f, o_steps = k+1, pulse o_valid, go to IDLE.
    - Chunks equal, k < NCHUNK-1: k ← k+1, stay in CMP.
    - Chunks equal, k = NCHUNK-1: o_f = 010, o_steps = NCHUNK, pulse o_valid, go to IDLE.
- Signed mode: invert the operand MSB (sign bit) of both latched operands at latch time, then compare unsigned. This makes −1 < 1 and most-negative < most-positive.
- o_f and o_steps hold their value from o_valid until the next result. They are not cleared on a new start.
- i_start while o_busy = 1 is ignored; no queuing.
- Changes to i_a, i_b and i_signed after the latch edge have no effect on the running comparison.
- Degenerate case CHUNK = WIDTH: every compare finishes in 1 step.

## Timing
- Latency: o_valid is high in the cycle after edge E0 + j + 1, where E0 is the start-sampling edge and j (0-based) is the index of the first differing chunk.
  - Best case is 1 edge; equal operands take NCHUNK edges.
- o_busy is high from the edge after E0 up to and including the edge that asserts o_valid. It is low during the o_valid cycle.
- Back-to-back: i_start high during the o_valid cycle is accepted. There is zero idle gap between operations.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Reset asserted mid-CMP aborts immediately. No o_valid is produced for the aborted operation.

## Structure
- Package comparator_pkg holds:
  - result constants CMP_GT = 3'b100, CMP_EQ = 3'b010, CMP_LT = 3'b001, CMP_NONE = 3'b000;
  - the FSM state encoding (ST_IDLE, ST_CMP).
- One combinational sub-module, comparator_chunk #(CHUNK). It takes two CHUNK-bit inputs and produces gt/eq/lt, reusing the single-cycle compare function.
- comparator_serial holds the FSM, operand/index registers, step counter and output registers.

## Test plan
All scenarios use WIDTH = 8, CHUNK = 2 (NCHUNK = 4).
- Reset: assert i_rst_n = 0 mid-CMP → all outputs 0 asynchronously. After release, no o_valid appears until a new start.
- Unsigned, MSB differs: A = 0x80, B = 0x01 → o_valid one edge after start, o_f = 100, o_steps = 1.
- Equal: A = B = 0x5A → o_valid after 4 edges, o_f = 010, o_steps = 4. o_busy is high for exactly 4 cycles.
- Last-chunk difference: A = 0x12, B = 0x13 unsigned → o_f = 001, o_steps = 4.
- Signed vs unsigned: A = 0xFF, B = 0x01.
  - i_signed = 1 → o_f = 001, o_steps = 1.
  - Same operands with i_signed = 0 → o_f = 100.
- Handshake:
  - i_start pulsed while busy → ignored.
  - New start in the o_valid cycle → accepted; next result is correct.
  - Operands toggled during busy → result unchanged.

Source files
------------

// File: rtl/comparator_pkg.sv
// comparator_pkg: result encodings and FSM states shared by the serial comparator.
package comparator_pkg;
    localparam logic [2:0] CMP_GT   = 3'b100;
    localparam logic [2:0] CMP_EQ   = 3'b010;
    localparam logic [2:0] CMP_LT   = 3'b001;
    localparam logic [2:0] CMP_NONE = 3'b000;
    typedef enum logic {ST_IDLE, ST_CMP} state_t;
endpackage

// File: rtl/comparator_chunk.sv
// comparator_chunk: single-cycle unsigned magnitude compare of one CHUNK-bit slice.
module comparator_chunk #(
    parameter int CHUNK = 2
) (
    input  logic [CHUNK-1:0] i_a,
    input  logic [CHUNK-1:0] i_b,
    output logic             o_gt,
    output logic             o_eq,
    output logic             o_lt
);
    assign o_gt = i_a > i_b;
    assign o_eq = i_a == i_b;
    assign o_lt = i_a < i_b;
endmodule

// File: rtl/comparator_serial.sv
// comparator_serial: multi-cycle magnitude comparator, MSB chunk first, early exit on first difference.
module comparator_serial
    import comparator_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic                           i_start,
    input  logic                           i_signed,
    input  logic [WIDTH-1:0]               i_a,
    input  logic [WIDTH-1:0]               i_b,
    output logic [2:0]                     o_f,
    output logic                           o_valid,
    output logic                           o_busy,
    output logic [$clog2(WIDTH/CHUNK):0]   o_steps
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int SW     = $clog2(NCHUNK) + 1;

    if (WIDTH < 1 || CHUNK < 1 || CHUNK > WIDTH || WIDTH % CHUNK != 0) begin : g_bad_params
        $error("comparator_serial: illegal WIDTH/CHUNK combination");
    end

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_a, r_b, w_sign_mask;
    logic [SW-1:0]    r_idx;
    logic             w_gt, w_eq, w_lt, w_done, w_finish, w_accept;
    logic [2:0]       w_f_nxt;

    // Flipping the sign bit maps two's-complement order onto unsigned order.
    assign w_sign_mask = WIDTH'(i_signed) << (WIDTH - 1);

    comparator_chunk #(.CHUNK(CHUNK)) u_chunk (
        .i_a  (r_a[WIDTH-1 -: CHUNK]),
        .i_b  (r_b[WIDTH-1 -: CHUNK]),
        .o_gt (w_gt),
        .o_eq (w_eq),
        .o_lt (w_lt)
    );

    always_comb begin
        w_done      = !w_eq || r_idx == SW'(NCHUNK - 1);
        w_state_nxt = r_state == ST_IDLE ? (i_start ? ST_CMP : ST_IDLE)
                                         : (w_done ? ST_IDLE : ST_CMP);
    end

    always_comb begin
        w_accept = r_state == ST_IDLE && i_start;
        w_finish = r_state == ST_CMP && w_done;
        w_f_nxt  = w_gt ? CMP_GT : w_lt ? CMP_LT : CMP_EQ;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_idx   <= '0;
            o_f     <= CMP_NONE;
            o_valid <= 1'b0;
            o_busy  <= 1'b0;
            o_steps <= '0;
        end else begin
            r_state <= w_state_nxt;
            o_valid <= w_finish;
            o_busy  <= w_state_nxt == ST_CMP;
            if (w_finish) begin
                o_f     <= w_f_nxt;
                o_steps <= r_idx + SW'(1);
            end
            // Operands shift left so the chunk under test is always the top slice.
            if (w_accept) begin
                r_a   <= i_a ^ w_sign_mask;
                r_b   <= i_b ^ w_sign_mask;
                r_idx <= '0;
            end else if (r_state == ST_CMP && !w_done) begin
                r_a   <= r_a << CHUNK;
                r_b   <= r_b << CHUNK;
                r_idx <= r_idx + SW'(1);
            end
        end
    end
endmodule

// File: tb/tb_comparator_serial.sv
// tb_comparator_serial: directed checks of result, step count, latency and handshake.
module tb_comparator_serial;
    logic       i_clk = 1'b0;
    logic       i_rst_n = 1'b0;
    logic       i_start = 1'b0;
    logic       i_signed = 1'b0;
    logic [7:0] i_a = '0;
    logic [7:0] i_b = '0;
    logic [2:0] o_f;
    logic       o_valid;
    logic       o_busy;
    logic [2:0] o_steps;
    int tests = 0;
    int fails = 0;

    comparator_serial #(.WIDTH(8), .CHUNK(2)) dut (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_start  (i_start),
        .i_signed (i_signed),
        .i_a      (i_a),
        .i_b      (i_b),
        .o_f      (o_f),
        .o_valid  (o_valid),
        .o_busy   (o_busy),
        .o_steps  (o_steps)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic go(input logic [7:0] a, input logic [7:0] b, input logic s);
        i_a = a;
        i_b = b;
        i_signed = s;
        i_start = 1'b1;
    endtask

    task automatic wait_res(input string tag, input logic [2:0] ef, input int es, input bit disturb);
        int n = 0;
        int busy = 0;
        bit got = 0;
        while (!got && n < 20) begin
            @(negedge i_clk);
            n++;
            i_start = 1'b0;
            if (o_valid) got = 1;
            else begin
                if (o_busy) busy++;
                if (disturb) begin
                    i_a = 8'($urandom);
                    i_b = 8'($urandom);
                    i_signed = ~i_signed;
                    i_start = 1'b1;
                end
            end
        end
        chk({tag, "_valid"}, 32'(got), 32'd1);
        chk({tag, "_f"}, 32'(o_f), 32'(ef));
        chk({tag, "_steps"}, 32'(o_steps), 32'(es));
        chk({tag, "_latency"}, 32'(n), 32'(es + 1));
        chk({tag, "_busy_cycles"}, 32'(busy), 32'(es));
        chk({tag, "_busy_low_at_valid"}, 32'(o_busy), 32'd0);
    endtask

    task automatic idle_after(input string tag, input logic [2:0] ef, input logic [2:0] es);
        @(negedge i_clk);
        chk({tag, "_no_extra_valid"}, 32'(o_valid), 32'd0);
        chk({tag, "_idle"}, 32'(o_busy), 32'd0);
        chk({tag, "_f_hold"}, 32'(o_f), 32'(ef));
        chk({tag, "_steps_hold"}, 32'(o_steps), 32'(es));
    endtask

    initial begin
        int nv;
        repeat (2) @(negedge i_clk);
        chk("rst_f", 32'(o_f), 32'd0);
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_steps", 32'(o_steps), 32'd0);
        i_rst_n = 1'b1;
        @(negedge i_clk);

        go(8'h80, 8'h01, 1'b0);
        wait_res("msb_gt", 3'b100, 1, 0);
        idle_after("msb_gt", 3'b100, 3'd1);

        go(8'h5A, 8'h5A, 1'b0);
        wait_res("equal", 3'b010, 4, 0);
        idle_after("equal", 3'b010, 3'd4);

        go(8'h12, 8'h13, 1'b0);
        wait_res("last_lt", 3'b001, 4, 0);

        go(8'hFF, 8'h01, 1'b1);
        wait_res("signed_lt", 3'b001, 1, 0);

        go(8'hFF, 8'h01, 1'b0);
        wait_res("unsigned_gt", 3'b100, 1, 0);

        go(8'h80, 8'h7F, 1'b1);
        wait_res("signed_minmax", 3'b001, 1, 0);

        go(8'h34, 8'h24, 1'b0);
        wait_res("second_gt", 3'b100, 2, 0);

        // start held during the valid cycle is accepted with no gap
        go(8'h5A, 8'h5B, 1'b0);
        wait_res("b2b_lt", 3'b001, 4, 0);
        idle_after("b2b_lt", 3'b001, 3'd4);

        // operands, mode and start toggled while busy must not disturb the result
        go(8'h12, 8'h13, 1'b0);
        wait_res("disturb", 3'b001, 4, 1);
        idle_after("disturb", 3'b001, 3'd4);

        go(8'h5A, 8'h5A, 1'b0);
        @(negedge i_clk);
        i_start = 1'b0;
        @(negedge i_clk);
        chk("abort_busy_before", 32'(o_busy), 32'd1);
        #2 i_rst_n = 1'b0;
        #1;
        chk("abort_f", 32'(o_f), 32'd0);
        chk("abort_busy", 32'(o_busy), 32'd0);
        chk("abort_steps", 32'(o_steps), 32'd0);
        chk("abort_valid", 32'(o_valid), 32'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        nv = 0;
        repeat (6) begin
            @(negedge i_clk);
            if (o_valid || o_busy) nv++;
        end
        chk("abort_quiet", 32'(nv), 32'd0);

        go(8'h01, 8'h80, 1'b0);
        wait_res("post_reset", 3'b001, 1, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
